unidad_aritmetica_secuencial: RTL and testbench

//  Multi-cycle, handshaked ALU; next generation of the combinational ALU in the CPU datapath.
//  Add/sub/shift/pass complete in 1 cycle; mul/div/mod use an iterative core over N cycles.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/unidad_aritmetica_secuencial_if.sv | 38 +++
 rtl/mul_div_iterativo.sv | 112 +++++++++++
 rtl/unidad_aritmetica_secuencial.sv | 194 +++++++++++++++++++
 tb/tb_unidad_aritmetica_secuencial.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types for the sequential ALU: operation codes, FSM
//                states and small decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Operation encodings as seen on the Sel port
    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_MUL   = 3'b010,
        OP_MOD   = 3'b011,
        OP_SRL   = 3'b100,
        OP_PASSB = 3'b101,
        OP_DIV   = 3'b110,
        OP_SLL   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Iteration counter width for the default 32-bit datapath
    localparam int N_DEFAULT = 32;
    localparam int CNT_W     = $clog2(N_DEFAULT);

    // Operations that go through the iterative multiply/divide core
    function automatic logic isMultiCycle(input op_e op);
        return (op == OP_MUL) || (op == OP_MOD) || (op == OP_DIV);
    endfunction

    // Operations that run the core in restoring-division mode
    function automatic logic isDivision(input op_e op);
        return (op == OP_MOD) || (op == OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/unidad_aritmetica_secuencial_if.sv
`default_nettype none
// ============================================================================
//  Module      : unidad_aritmetica_secuencial_if
//  Description : Request/response bundle of the sequential ALU. The master
//                side issues operations and consumes results; the slave side
//                is the ALU itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface unidad_aritmetica_secuencial_if #(
    parameter int N = 32
) ();
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [2:0]   Sel;
    logic         valid_in;
    logic         ready_out;
    logic [N-1:0] C;
    logic         banNegativo;
    logic         banCero;
    logic         banDesborde;
    logic         banAcarreo;
    logic         divCero;
    logic         valid_out;
    logic         ready_in;

    modport master (
        output A, B, Sel, valid_in, ready_in,
        input  ready_out, C, banNegativo, banCero, banDesborde, banAcarreo,
               divCero, valid_out
    );

    modport slave (
        input  A, B, Sel, valid_in, ready_in,
        output ready_out, C, banNegativo, banCero, banDesborde, banAcarreo,
               divCero, valid_out
    );
endinterface
`default_nettype wire

// File: rtl/mul_div_iterativo.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_iterativo
//  Description : Iterative N-cycle core. Shift-add multiply (lo = product low,
//                hi = product high) or restoring divide (lo = quotient,
//                hi = remainder). The first iteration is applied on the start
//                edge itself, so results are final when done pulses, N-1
//                cycles after start.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_iterativo #(
    parameter int N = 32
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         start,
    input  wire logic         is_div,
    input  wire logic [N-1:0] A,
    input  wire logic [N-1:0] B,
    output logic              busy,
    output logic              done,
    output logic [N-1:0]      lo,
    output logic [N-1:0]      hi
);
    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [N-1:0]  rHi;
    logic [N-1:0]  rLo;
    logic [N-1:0]  rOpnd;
    logic          rIsDiv;
    logic          rBusy;
    logic          rDone;
    logic [CW-1:0] rCnt;

    logic [N-1:0]  wSrcHi;
    logic [N-1:0]  wSrcLo;
    logic [N-1:0]  wSrcOpnd;
    logic          wSrcDiv;
    logic [N:0]    wSum;
    logic [N:0]    wShifted;
    logic [N:0]    wDiff;
    logic [N-1:0]  wStepHi;
    logic [N-1:0]  wStepLo;

    // Iteration source: fresh operands on start, working registers otherwise.
    // Multiply keeps the multiplier in lo; divide keeps the dividend in lo.
    always_comb begin
        wSrcDiv  = start ? is_div : rIsDiv;
        wSrcHi   = start ? '0 : rHi;
        wSrcLo   = start ? (is_div ? A : B) : rLo;
        wSrcOpnd = start ? (is_div ? B : A) : rOpnd;
    end

    // One multiply or restoring-divide step
    always_comb begin
        wSum     = {1'b0, wSrcHi} + (wSrcLo[0] ? {1'b0, wSrcOpnd} : {(N+1){1'b0}});
        wShifted = {wSrcHi, wSrcLo[N-1]};
        wDiff    = wShifted - {1'b0, wSrcOpnd};
        wStepHi  = wSum[N:1];
        wStepLo  = {wSum[0], wSrcLo[N-1:1]};
        if (wSrcDiv) begin
            // wDiff[N] is the borrow; a zero divisor never borrows, which
            // yields an all-ones quotient and the dividend as remainder.
            if (!wDiff[N]) begin
                wStepHi = wDiff[N-1:0];
                wStepLo = {wSrcLo[N-2:0], 1'b1};
            end else begin
                wStepHi = wShifted[N-1:0];
                wStepLo = {wSrcLo[N-2:0], 1'b0};
            end
        end
    end

    // Working registers, iteration counter and completion pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rHi    <= '0;
            rLo    <= '0;
            rOpnd  <= '0;
            rIsDiv <= 1'b0;
            rBusy  <= 1'b0;
            rDone  <= 1'b0;
            rCnt   <= '0;
        end else begin
            rDone <= 1'b0;
            if (start) begin
                rHi    <= wStepHi;
                rLo    <= wStepLo;
                rOpnd  <= wSrcOpnd;
                rIsDiv <= is_div;
                rCnt   <= CW'(1);
                rBusy  <= 1'b1;
            end else if (rBusy) begin
                rHi  <= wStepHi;
                rLo  <= wStepLo;
                rCnt <= rCnt + 1'b1;
                if (rCnt == LAST) begin
                    rBusy <= 1'b0;
                    rDone <= 1'b1;
                end
            end
        end
    end

    assign busy = rBusy;
    assign done = rDone;
    assign lo   = rLo;
    assign hi   = rHi;

endmodule
`default_nettype wire

// File: rtl/unidad_aritmetica_secuencial.sv
`default_nettype none
// ============================================================================
//  Module      : unidad_aritmetica_secuencial
//  Description : Handshaked multi-cycle ALU. Add/sub/shift/pass finish in one
//                cycle; mul/div/mod run through the iterative core. Result
//                and NZVC flags are held until the consumer takes them.
//  Revision    : 1.0 - initial release
// ============================================================================
module unidad_aritmetica_secuencial #(
    parameter int N = 32
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    unidad_aritmetica_secuencial_if.slave bus
);
    import alu_pkg::*;

    localparam int            CW   = $clog2(N);
    localparam int            SH_W = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e        rState;
    state_e        wNextState;
    logic [CW-1:0] rCount;
    op_e           rOp;
    op_e           wSel;

    logic          wAccept;
    logic          wStart;
    logic          wIsDiv;
    logic          wCalcExit;
    logic          wLoad;

    logic          wCoreBusy;
    logic          wCoreDone;
    logic [N-1:0]  wCoreLo;
    logic [N-1:0]  wCoreHi;

    logic [N:0]    wAddFull;
    logic [N:0]    wSubFull;
    logic [N-1:0]  wRes;
    logic          wCarry;
    logic          wOvf;
    logic          wPass;

    logic [N-1:0]  rC;
    logic          rNeg;
    logic          rZero;
    logic          rOvf;
    logic          rCarry;
    logic          rDivZero;

    assign wSel      = op_e'(bus.Sel);
    assign wAccept   = (rState == IDLE) && bus.valid_in;
    assign wStart    = wAccept && isMultiCycle(wSel);
    assign wIsDiv    = isDivision(wSel);
    // The core finishes its last iteration exactly as the counter reaches LAST
    assign wCalcExit = (rCount == LAST) && !wCoreBusy;
    assign wLoad     = (wAccept && !isMultiCycle(wSel)) ||
                       ((rState == CALC) && wCoreDone);

    mul_div_iterativo #(
        .N (N)
    ) uCore (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (wStart),
        .is_div (wIsDiv),
        .A      (bus.A),
        .B      (bus.B),
        .busy   (wCoreBusy),
        .done   (wCoreDone),
        .lo     (wCoreLo),
        .hi     (wCoreHi)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rState <= IDLE;
        end else begin
            rState <= wNextState;
        end
    end

    // Next-state logic; requests outside IDLE are simply not accepted
    always_comb begin
        wNextState = rState;
        case (rState)
            IDLE: if (wAccept) wNextState = isMultiCycle(wSel) ? CALC : DONE;
            CALC: if (wCalcExit) wNextState = DONE;
            DONE: if (bus.ready_in) wNextState = IDLE;
            default: wNextState = IDLE;
        endcase
    end

    // Iteration counter, running only while in CALC
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rCount <= '0;
        end else if (rState == CALC) begin
            rCount <= rCount + 1'b1;
        end else begin
            rCount <= '0;
        end
    end

    // Latch the operation on accept so the result mux ignores later Sel changes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rOp <= OP_ADD;
        end else if (wAccept) begin
            rOp <= wSel;
        end
    end

    // Result and raw C/V selection: live operands in IDLE, core output in CALC
    always_comb begin
        wAddFull = {1'b0, bus.A} + {1'b0, bus.B};
        wSubFull = {1'b0, bus.A} - {1'b0, bus.B};
        wRes     = '0;
        wCarry   = 1'b0;
        wOvf     = 1'b0;
        wPass    = 1'b0;
        if (rState == IDLE) begin
            case (wSel)
                OP_ADD: begin
                    wRes   = wAddFull[N-1:0];
                    wCarry = wAddFull[N];
                    wOvf   = (bus.A[N-1] == bus.B[N-1]) && (wAddFull[N-1] != bus.A[N-1]);
                end
                OP_SUB: begin
                    wRes   = wSubFull[N-1:0];
                    wCarry = !wSubFull[N];
                    wOvf   = (bus.A[N-1] != bus.B[N-1]) && (wSubFull[N-1] != bus.A[N-1]);
                end
                OP_SRL:   wRes = bus.A >> bus.B[SH_W-1:0];
                OP_SLL:   wRes = bus.A << bus.B[SH_W-1:0];
                OP_PASSB: begin
                    wRes  = bus.B;
                    wPass = 1'b1;
                end
                default: ;
            endcase
        end else begin
            case (rOp)
                OP_MUL: begin
                    wRes   = wCoreLo;
                    wCarry = |wCoreHi;
                end
                OP_DIV:  wRes = wCoreLo;
                OP_MOD:  wRes = wCoreHi;
                default: ;
            endcase
        end
    end

    // Output registers, held until the next completed operation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rC     <= '0;
            rNeg   <= 1'b0;
            rZero  <= 1'b0;
            rOvf   <= 1'b0;
            rCarry <= 1'b0;
        end else if (wLoad) begin
            rC     <= wRes;
            rNeg   <= !wPass && wRes[N-1];
            rZero  <= !wPass && (wRes == '0);
            rOvf   <= wOvf;
            rCarry <= wCarry;
        end
    end

    // Divide-by-zero indication, refreshed on every accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rDivZero <= 1'b0;
        end else if (wAccept) begin
            rDivZero <= wIsDiv && (bus.B == '0);
        end
    end

    assign bus.ready_out   = (rState == IDLE);
    assign bus.valid_out   = (rState == DONE);
    assign bus.C           = rC;
    assign bus.banNegativo = rNeg;
    assign bus.banCero     = rZero;
    assign bus.banDesborde = rOvf;
    assign bus.banAcarreo  = rCarry;
    assign bus.divCero     = rDivZero;

endmodule
`default_nettype wire

// File: tb/tb_unidad_aritmetica_secuencial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unidad_aritmetica_secuencial
//  Description : Self-checking bench for the sequential ALU at N=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unidad_aritmetica_secuencial;

    typedef struct packed {
        logic [7:0] c;
        logic [4:0] flags;   // {N, Z, V, C, divCero}
    } exp_t;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [4:0] flags;
        int         lat;
        string      name;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sbQ[$];
    vec_t tbl[$];

    unidad_aritmetica_secuencial_if #(.N(8)) bus ();

    unidad_aritmetica_secuencial #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] dutFlags();
        return {bus.banNegativo, bus.banCero, bus.banDesborde, bus.banAcarreo, bus.divCero};
    endfunction

    // Independent reference: plain arithmetic, no iteration
    function automatic exp_t model(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        exp_t       r;
        logic [8:0] s;
        logic [15:0] p;
        logic [7:0] c;
        logic       v, cy, dz, pass;
        s = 9'd0; p = 16'd0; c = 8'd0; v = 1'b0; cy = 1'b0; dz = 1'b0; pass = 1'b0;
        case (sel)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; c = s[7:0]; cy = s[8];
                        v = (a[7] == b[7]) && (c[7] != a[7]); end
            3'd1: begin c = a - b; cy = (a >= b); v = (a[7] != b[7]) && (c[7] != a[7]); end
            3'd2: begin p = {8'd0, a} * {8'd0, b}; c = p[7:0]; cy = (p[15:8] != 8'd0); end
            3'd3: begin dz = (b == 8'd0); c = dz ? a : (a % b); end
            3'd4: c = a >> b[2:0];
            3'd5: begin c = b; pass = 1'b1; end
            3'd6: begin dz = (b == 8'd0); c = dz ? 8'hFF : (a / b); end
            default: c = a << b[2:0];
        endcase
        r.c     = c;
        r.flags = {!pass && c[7], !pass && (c == 8'd0), v, cy, dz};
        return r;
    endfunction

    function automatic int expLat(input logic [2:0] sel);
        return (sel == 3'd2 || sel == 3'd3 || sel == 3'd6) ? 9 : 1;
    endfunction

    function automatic vec_t mk(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [4:0] f, input string n);
        vec_t v;
        v.sel = sel; v.a = a; v.b = b; v.c = c; v.flags = f; v.lat = expLat(sel); v.name = n;
        return v;
    endfunction

    // Issue one operation (called at a negedge), check latency and result,
    // optionally stall the consumer for 'hold' cycles while checking stability.
    task automatic runOp(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                         input exp_t e, input int lat, input int hold, input string name);
        int   w;
        int   n;
        exp_t got;
        bus.Sel = sel; bus.A = a; bus.B = b; bus.valid_in = 1'b1;
        bus.ready_in = (hold == 0);
        w = 0;
        while (!bus.ready_out && w < 20) begin @(negedge clk); w++; end
        chk({name, "_ready"}, 32'(bus.ready_out), 32'd1);
        sbQ.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.valid_in = 1'b0; bus.A = ~a; bus.B = ~b; bus.Sel = ~sel;
        n = 1;
        while (!bus.valid_out && n < 40) begin @(negedge clk); n++; end
        chk({name, "_latency"}, 32'(n), 32'(lat));
        got = (sbQ.size() > 0) ? sbQ.pop_front() : '0;
        chk({name, "_C"}, 32'(bus.C), 32'(got.c));
        chk({name, "_flags"}, 32'(dutFlags()), 32'(got.flags));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, "_hold"}, {19'd0, bus.valid_out, bus.C, dutFlags()}, {19'd0, 1'b1, got.c, got.flags});
        end
        bus.ready_in = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        logic [2:0] s;
        logic [7:0] ra, rb;
        int   n;
        checks = 0; errors = 0;
        rst_n = 1'b0;
        bus.A = 8'd0; bus.B = 8'd0; bus.Sel = 3'd0; bus.valid_in = 1'b0; bus.ready_in = 1'b1;

        //            sel   A      B      C      NZVCd     name
        tbl.push_back(mk(3'd0, 8'h7F, 8'h01, 8'h80, 5'b10100, "add_ovf"));
        tbl.push_back(mk(3'd0, 8'hFF, 8'h01, 8'h00, 5'b01010, "add_carry"));
        tbl.push_back(mk(3'd0, 8'h80, 8'h80, 8'h00, 5'b01110, "add_neg_ovf"));
        tbl.push_back(mk(3'd1, 8'h05, 8'h07, 8'hFE, 5'b10000, "sub_borrow"));
        tbl.push_back(mk(3'd1, 8'h80, 8'h01, 8'h7F, 5'b00110, "sub_ovf"));
        tbl.push_back(mk(3'd1, 8'h07, 8'h07, 8'h00, 5'b01010, "sub_zero"));
        tbl.push_back(mk(3'd2, 8'h10, 8'h10, 8'h00, 5'b01010, "mul_hi"));
        tbl.push_back(mk(3'd2, 8'h0C, 8'h0B, 8'h84, 5'b10000, "mul_lo"));
        tbl.push_back(mk(3'd6, 8'd200, 8'd7, 8'h1C, 5'b00000, "div"));
        tbl.push_back(mk(3'd3, 8'd200, 8'd7, 8'h04, 5'b00000, "mod"));
        tbl.push_back(mk(3'd6, 8'h55, 8'h00, 8'hFF, 5'b10001, "div_zero"));
        tbl.push_back(mk(3'd3, 8'h55, 8'h00, 8'h55, 5'b00001, "mod_zero"));
        tbl.push_back(mk(3'd4, 8'h96, 8'h0B, 8'h12, 5'b00000, "srl"));
        tbl.push_back(mk(3'd7, 8'h96, 8'h08, 8'h96, 5'b10000, "sll_amt0"));
        tbl.push_back(mk(3'd7, 8'h81, 8'h01, 8'h02, 5'b00000, "sll"));
        tbl.push_back(mk(3'd5, 8'h12, 8'h80, 8'h80, 5'b00000, "passB"));
        tbl.push_back(mk(3'd6, 8'h05, 8'h09, 8'h00, 5'b01000, "div_small"));
        tbl.push_back(mk(3'd3, 8'h05, 8'h09, 8'h05, 5'b00000, "mod_small"));

        repeat (2) @(negedge clk);
        chk("reset_valid_out", 32'(bus.valid_out), 32'd0);
        chk("reset_ready_out", 32'(bus.ready_out), 32'd1);
        chk("reset_C", 32'(bus.C), 32'd0);
        chk("reset_flags", 32'(dutFlags()), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        foreach (tbl[i]) begin
            e.c = tbl[i].c; e.flags = tbl[i].flags;
            runOp(tbl[i].sel, tbl[i].a, tbl[i].b, e, tbl[i].lat, 0, tbl[i].name);
        end

        // Held result with stalled consumer; requests during CALC ignored
        bus.Sel = 3'd2; bus.A = 8'h03; bus.B = 8'h05; bus.valid_in = 1'b1; bus.ready_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.Sel = 3'd0; bus.A = 8'hFF; bus.B = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            chk("calc_ready_out", 32'(bus.ready_out), 32'd0);
            @(negedge clk);
        end
        bus.valid_in = 1'b0;
        n = 5;
        while (!bus.valid_out && n < 40) begin @(negedge clk); n++; end
        chk("hold_latency", 32'(n), 32'd9);
        for (int i = 0; i < 5; i++) begin
            chk("hold_stable", {19'd0, bus.valid_out, bus.C, dutFlags()}, {19'd0, 1'b1, 8'h0F, 5'b00000});
            @(negedge clk);
        end
        bus.ready_in = 1'b1;
        @(negedge clk);
        chk("release_valid_out", 32'(bus.valid_out), 32'd0);
        chk("release_ready_out", 32'(bus.ready_out), 32'd1);
        @(negedge clk);
        chk("no_queued_op", 32'(bus.valid_out), 32'd0);

        // Reset in the middle of a division
        bus.Sel = 3'd6; bus.A = 8'd200; bus.B = 8'd7; bus.valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.valid_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_valid_out", 32'(bus.valid_out), 32'd0);
        chk("midreset_ready_out", 32'(bus.ready_out), 32'd1);
        chk("midreset_C", 32'(bus.C), 32'd0);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.valid_out) n++;
        end
        chk("midreset_no_output", 32'(n), 32'd0);
        e.c = 8'h1C; e.flags = 5'b00000;
        runOp(3'd6, 8'd200, 8'd7, e, 9, 0, "after_reset_div");
        e.c = 8'h07; e.flags = 5'b00000;
        runOp(3'd0, 8'h03, 8'h04, e, 1, 0, "after_reset_add");

        // Random operations against the reference, consumer randomly stalled
        for (int i = 0; i < 40; i++) begin
            s  = 3'($urandom_range(0, 7));
            ra = 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            runOp(s, ra, rb, model(s, ra, rb), expLat(s), $urandom_range(0, 3), "rand");
        end

        chk("scoreboard_empty", 32'(sbQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
